// File: rtl/fix_to_float.sv
// Signed fixed-point to {sign, biased exponent, mantissa} float converter.
// Normalises iteratively (one left shift per cycle) behind ready/valid handshakes.
module fix_to_float #(
    parameter int n_int  = 8,
    parameter int n_mant = 23,
    parameter int n_exp  = 8,
    parameter int n_frac = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [n_int+n_mant:0] in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [n_exp+n_frac:0]       out,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int W    = n_int + n_mant + 1;
    localparam int BIAS = (1 << (n_exp - 1)) - 1;
    localparam int KW   = $clog2(W) + 1;
    localparam int EW   = ((n_exp > $clog2(W)) ? n_exp : $clog2(W)) + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [EW-1:0] EXP_OFFSET = EW'(BIAS + n_int);
    localparam logic signed [EW-1:0] EXP_SAT    = EW'((1 << n_exp) - 1);
    localparam logic [n_exp-1:0]     EXP_MAX    = n_exp'((1 << n_exp) - 2);

    logic [1:0]              state;
    logic [W-1:0]            mag;
    logic [KW-1:0]           k;
    logic                    sign;
    logic                    zero;
    logic [W-1:0]            in_mag;
    logic signed [EW-1:0]    k_s;
    logic signed [EW-1:0]    exp_calc;
    logic [W-2+n_frac:0]     frac_wide;
    logic [n_frac-1:0]       frac_field;
    logic [n_exp+n_frac:0]   result;

    // The most negative operand negates to 2^(W-1), which is still correct as unsigned.
    assign in_mag = in[W-1] ? $unsigned(-in) : $unsigned(in);

    assign k_s      = EW'(k);
    assign exp_calc = EXP_OFFSET - k_s;

    // Appending zeros covers both truncation and right-padding of the mantissa.
    assign frac_wide  = {mag[W-2:0], {n_frac{1'b0}}};
    assign frac_field = frac_wide[W-2+n_frac -: n_frac];

    always_comb begin
        result = '0;
        if (zero) begin
            result = '0;
        end else if (exp_calc >= EXP_SAT) begin
            result = {sign, EXP_MAX, {n_frac{1'b1}}};
        end else if (exp_calc <= 0) begin
            result = '0;
        end else begin
            result = {sign, exp_calc[n_exp-1:0], frac_field};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mag   <= '0;
            k     <= '0;
            sign  <= 1'b0;
            zero  <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in[W-1];
                        mag   <= in_mag;
                        k     <= '0;
                        zero  <= (in == '0);
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (zero || mag[W-1]) begin
                        out   <= result;
                        state <= DONE;
                    end else begin
                        mag <= mag << 1;
                        k   <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: doc/fix_to_float.md
# fix_to_float

Sequential converter from signed two's-complement fixed-point to a sign/biased-exponent/mantissa floating-point word. It is the counterpart of the filter's fixed-point rescaling path: filter outputs leave the fixed-point datapath through this block toward float consumers such as the host interface and the logging path. Normalisation runs iteratively, one left shift per cycle. Ready/valid handshakes sit on both sides.

## Interface
- `n_int`, default 8: integer bits of the input, excluding sign.
- `n_mant`, default 23: fractional bits of the input.
- `n_exp`, default 8: exponent field width of the output.
- `n_frac`, default 23: mantissa field width of the output, hidden bit not stored.
- Derived, not overridable: W = n_int+n_mant+1, BIAS = 2^(n_exp-1)-1.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in`, input, W (`[n_int+n_mant:0]`), signed: fixed-point operand.
- `in_valid`, input, 1: operand present.
- `in_ready`, output, 1: block can accept an operand.
- `out`, output, 1+n_exp+n_frac: result, laid out {sign, exponent, mantissa}.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.

## Operation
- FSM states are IDLE, NORM and DONE.
- IDLE:
  - `in_ready`=1, decoded from the state.
  - On `in_valid && in_ready`, register the sign (in[W-1]) and magnitude = |in| as a W-bit unsigned value. The most negative input gives 2^(W-1), which fits.
  - Clear shift count k, set the zero flag if in==0, go to NORM.
- NORM, one decision per edge:
  - If the zero flag is set: load `out`=0 (sign forced 0), go to DONE.
  - Else if mag[W-1]=1: load the result, go to DONE.
  - Else: mag <<= 1, k += 1, stay in NORM.
- Result fields:
  - sign = registered sign.
  - exponent = BIAS + (W-1-n_mant) - k.
  - mantissa = mag[W-2:0] truncated to its top n_frac bits, or zero-padded on the right if W-1 < n_frac. Rounding is toward zero (truncate).
- Exponent range:
  - If the computed exponent is ≥ 2^n_exp-1, saturate to exponent 2^n_exp-2 and mantissa all-ones, sign kept.
  - If it is ≤ 0, flush to all-zero with sign 0.
  - At the default parameters neither case can occur.
  - Exponent arithmetic uses a signed width of max(n_exp, clog2(W))+2 bits.
- DONE:
  - `out_valid`=1 and `out` held stable.
  - On `out_valid && out_ready`, go to IDLE. `out` keeps its value; only `out_valid` drops.
- `in_ready`=0 in NORM and DONE. There is no overlap: a new operand is accepted only in IDLE, at the earliest the cycle after the handshake.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0. Internal mag, k, sign and flag are all cleared.
- Reset asserted mid-operation (in NORM or DONE) aborts immediately and asynchronously. The pending result is lost and never appears on `out`.
- Latency from the accept edge E0 to the first cycle with `out_valid`=1 is k+1 edges, where k is the number of leading zeros of the magnitude.
  - Minimum is 1, for zero or a magnitude with MSB set.
  - Maximum is W, for magnitude 1.
- Minimum initiation interval is k+3 cycles, with `out_ready` held high.
- `out_ready` high while not in DONE is ignored. `in_valid` is ignored outside IDLE, and `in` may change freely there.
- `out_ready` held low keeps DONE indefinitely with `out` bit-stable.

## Test plan
- 1.0 (in=0x00800000, defaults), `out_ready`=1 → `out`=0x3F800000, `out_valid` 9 edges after accept, `in_ready` back high the following cycle.
- -1.0 (0xFF800000) → 0xBF800000. 0x80000000 (-256.0) → 0xC3800000 at latency 1. 0x00000000 → 0x00000000 at latency 1.
- 0x00000001 (2^-23) → 0x34000000 at latency 32. 0x7FFFFFFF → 0x437FFFFF, checking truncation, at latency 2.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises → `out` is stable, `in_ready`=0, and a second `in_valid` is not accepted. Release → one handshake, then IDLE.
- Reset: assert `rst_n`=0 for 1 cycle during NORM while converting 0x00000001 → `out_valid`=0 and `in_ready`=1 immediately, no stale output. The next operand 0x00800000 converts correctly.
- Random: 10k random operands with random `out_ready` gaps → every result matches a reference model (truncating float conversion), and results appear in order with none dropped or duplicated.
